// File: rtl/datapath_regs.sv
// Datapath register bank with a shared bus and a small ALU. It acts on the
// control word presented each cycle.
module datapath_regs #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       read_en,
  input  logic [15:0]      write_en,
  input  logic [15:0]      inc_en,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic             dmem_we,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] bus_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] pc, dar, ir, ac, r, r1, r2, r3, r4, r5;
  logic             z_flag;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_res;
  logic             unused_bits;

  function automatic logic [WIDTH-1:0] alu_calc(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return {a[WIDTH-2:0], 1'b0};
      3'd4:    return {1'b0, a[WIDTH-1:1]};
      default: return a;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    case (read_en)
      4'd2:    bus = dar;
      4'd5:    bus = ac;
      4'd6:    bus = r;
      4'd7:    bus = r1;
      4'd8:    bus = r2;
      4'd9:    bus = r3;
      4'd10:   bus = r4;
      4'd11:   bus = r5;
      4'd12:   bus = dmem_rdata;
      4'd13:   bus = imem_rdata;
      default: bus = '0;
    endcase
  end

  assign alu_res = alu_calc(alu_op, ac, r);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= '0;
      dar    <= '0;
      ir     <= '0;
      ac     <= '0;
      r      <= '0;
      r1     <= '0;
      r2     <= '0;
      r3     <= '0;
      r4     <= '0;
      r5     <= '0;
      z_flag <= 1'b0;
    end else begin
      if (write_en[1])      pc <= bus;
      else if (inc_en[1])   pc <= pc + ONE;

      if (write_en[2])      dar <= bus;
      else if (inc_en[3])   dar <= dar + ONE;

      if (write_en[4])      ir <= bus;

      // The ALU writeback wins over a bus load, which wins over an increment.
      if (write_en[15])     ac <= alu_res;
      else if (write_en[5]) ac <= bus;
      else if (inc_en[2])   ac <= ac + ONE;

      if (write_en[6])      r <= bus;

      if (write_en[7])      r1 <= bus;
      else if (inc_en[4])   r1 <= r1 + ONE;

      if (write_en[8])      r2 <= bus;
      else if (inc_en[5])   r2 <= r2 + ONE;

      if (write_en[9])      r3 <= bus;
      else if (inc_en[6])   r3 <= r3 + ONE;

      if (write_en[10])     r4 <= bus;
      if (write_en[11])     r5 <= bus;

      // The zero flag follows the ALU when requested, otherwise a bus load of AC.
      if (write_en[14])     z_flag <= (alu_res == '0);
      else if (write_en[5]) z_flag <= (bus == '0);
    end
  end

  assign imem_addr   = pc;
  assign dmem_addr   = dar;
  assign dmem_wdata  = bus;
  assign dmem_we     = write_en[12];
  assign instruction = ir;
  assign z           = {{(WIDTH-1){1'b0}}, z_flag};
  assign bus_out     = bus;

  assign unused_bits = ^{write_en[0], write_en[3], write_en[13],
                         inc_en[0], inc_en[15:7]};

endmodule

// File: tb/tb_datapath_regs.sv
// Directed bench for datapath_regs: register loads, ALU, flags, store strobe,
// wrap-around and priority conflicts.
module tb_datapath_regs;

  localparam int WIDTH = 16;

  logic             clock;
  logic             reset_n;
  logic [3:0]       read_en;
  logic [15:0]      write_en;
  logic [15:0]      inc_en;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] dmem_rdata;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic             dmem_we;
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] bus_out;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_regs #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .alu_op(alu_op), .imem_rdata(imem_rdata),
    .dmem_rdata(dmem_rdata), .imem_addr(imem_addr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .instruction(instruction),
    .z(z), .bus_out(bus_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply the current control word on one rising edge, then return to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    write_en = '0;
    inc_en   = '0;
    alu_op   = '0;
    #1;
  endtask

  // Load a constant into the destinations named by we through the imem bus path.
  task automatic load(input logic [15:0] we, input logic [WIDTH-1:0] val);
    read_en    = 4'd13;
    imem_rdata = val;
    write_en   = we;
    tick();
  endtask

  task automatic test_reset();
    load(16'h0020, 16'h00FF);
    load(16'h0012, 16'h0012);
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h00FF) begin n_fail++; $display("FAIL pre_reset_ac: got %h expected %h", bus_out, 16'h00FF); end
    n_checks++; if (imem_addr !== 16'h0012) begin n_fail++; $display("FAIL pre_reset_pc: got %h expected %h", imem_addr, 16'h0012); end
    reset_n = 1'b0; #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ac: got %h expected %h", bus_out, 16'h0000); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 16'h0000); end
    n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h expected %h", instruction, 16'h0000); end
    n_checks++; if (dmem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_dar: got %h expected %h", dmem_addr, 16'h0000); end
    n_checks++; if (z !== 16'h0000) begin n_fail++; $display("FAIL reset_z: got %h expected %h", z, 16'h0000); end
    @(negedge clock);
    reset_n = 1'b1;
    read_en = 4'd0;
    for (int i = 0; i < 3; i++) tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL idle_ac: got %h expected %h", bus_out, 16'h0000); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL idle_pc: got %h expected %h", imem_addr, 16'h0000); end
    n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL idle_ir: got %h expected %h", instruction, 16'h0000); end
  endtask

  task automatic test_immediate_load();
    load(16'h0020, 16'h00A5);
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h00A5) begin n_fail++; $display("FAIL imm_ac: got %h expected %h", bus_out, 16'h00A5); end
    n_checks++; if (z !== 16'h0000) begin n_fail++; $display("FAIL imm_z: got %h expected %h", z, 16'h0000); end
    write_en = 16'h0040;
    tick();
    read_en = 4'd6; #1;
    n_checks++; if (bus_out !== 16'h00A5) begin n_fail++; $display("FAIL imm_r: got %h expected %h", bus_out, 16'h00A5); end
    load(16'h0010, 16'hBEEF);
    n_checks++; if (instruction !== 16'hBEEF) begin n_fail++; $display("FAIL imm_ir: got %h expected %h", instruction, 16'hBEEF); end
  endtask

  task automatic test_subtract();
    alu_op = 3'd2; write_en = 16'hC000;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL sub_ac: got %h expected %h", bus_out, 16'h0000); end
    n_checks++; if (z !== 16'h0001) begin n_fail++; $display("FAIL sub_z: got %h expected %h", z, 16'h0001); end
    alu_op = 3'd1; write_en = 16'hC000;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h00A5) begin n_fail++; $display("FAIL add_ac: got %h expected %h", bus_out, 16'h00A5); end
    n_checks++; if (z !== 16'h0000) begin n_fail++; $display("FAIL add_z: got %h expected %h", z, 16'h0000); end
  endtask

  task automatic test_store();
    load(16'h0004, 16'h0030);
    load(16'h0020, 16'h1234);
    read_en = 4'd5; write_en = 16'h1000; #1;
    n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b expected %b", dmem_we, 1'b1); end
    n_checks++; if (dmem_addr !== 16'h0030) begin n_fail++; $display("FAIL store_addr: got %h expected %h", dmem_addr, 16'h0030); end
    n_checks++; if (dmem_wdata !== 16'h1234) begin n_fail++; $display("FAIL store_wdata: got %h expected %h", dmem_wdata, 16'h1234); end
    tick();
    n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL store_we_after: got %b expected %b", dmem_we, 1'b0); end
    dmem_rdata = 16'h5A5A; read_en = 4'd12; #1;
    n_checks++; if (bus_out !== 16'h5A5A) begin n_fail++; $display("FAIL dmem_read_bus: got %h expected %h", bus_out, 16'h5A5A); end
  endtask

  task automatic test_wrap_shift();
    load(16'h0002, 16'hFFFF);
    inc_en = 16'h0002;
    tick();
    n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", imem_addr, 16'h0000); end
    load(16'h0020, 16'h8001);
    alu_op = 3'd3; write_en = 16'hC000;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h0002) begin n_fail++; $display("FAIL shl: got %h expected %h", bus_out, 16'h0002); end
    load(16'h0020, 16'h8001);
    alu_op = 3'd4; write_en = 16'hC000;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h4000) begin n_fail++; $display("FAIL shr: got %h expected %h", bus_out, 16'h4000); end
  endtask

  task automatic test_regfile();
    load(16'h0080, 16'h0101);
    load(16'h0100, 16'h0202);
    load(16'h0200, 16'hFFFF);
    load(16'h0400, 16'h0404);
    load(16'h0800, 16'h0505);
    load(16'h0006, 16'h0777);
    inc_en = 16'h007A;  // PC, DAR, R1, R2, R3
    tick();
    n_checks++; if (imem_addr !== 16'h0778) begin n_fail++; $display("FAIL multi_pc: got %h expected %h", imem_addr, 16'h0778); end
    n_checks++; if (dmem_addr !== 16'h0778) begin n_fail++; $display("FAIL multi_dar: got %h expected %h", dmem_addr, 16'h0778); end
    read_en = 4'd7; #1;
    n_checks++; if (bus_out !== 16'h0102) begin n_fail++; $display("FAIL r1_inc: got %h expected %h", bus_out, 16'h0102); end
    read_en = 4'd8; #1;
    n_checks++; if (bus_out !== 16'h0203) begin n_fail++; $display("FAIL r2_inc: got %h expected %h", bus_out, 16'h0203); end
    read_en = 4'd9; #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL r3_wrap: got %h expected %h", bus_out, 16'h0000); end
    read_en = 4'd10; #1;
    n_checks++; if (bus_out !== 16'h0404) begin n_fail++; $display("FAIL r4_hold: got %h expected %h", bus_out, 16'h0404); end
    read_en = 4'd11; #1;
    n_checks++; if (bus_out !== 16'h0505) begin n_fail++; $display("FAIL r5_hold: got %h expected %h", bus_out, 16'h0505); end
    read_en = 4'd2; #1;
    n_checks++; if (bus_out !== 16'h0778) begin n_fail++; $display("FAIL dar_bus: got %h expected %h", bus_out, 16'h0778); end
    load(16'h0020, 16'h0000);
    n_checks++; if (z !== 16'h0001) begin n_fail++; $display("FAIL z_bus_load: got %h expected %h", z, 16'h0001); end
    inc_en = 16'h0004;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h0001) begin n_fail++; $display("FAIL ac_inc: got %h expected %h", bus_out, 16'h0001); end
    n_checks++; if (z !== 16'h0001) begin n_fail++; $display("FAIL ac_inc_z_hold: got %h expected %h", z, 16'h0001); end
  endtask

  task automatic test_conflicts();
    load(16'h0040, 16'h00A5);
    read_en = 4'd13; imem_rdata = 16'h0007; write_en = 16'h0020; inc_en = 16'h0004;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h0007) begin n_fail++; $display("FAIL load_beats_inc: got %h expected %h", bus_out, 16'h0007); end
    read_en = 4'd13; imem_rdata = 16'h1111; alu_op = 3'd1; write_en = 16'h8020;
    tick();
    read_en = 4'd5; #1;
    n_checks++; if (bus_out !== 16'h00AC) begin n_fail++; $display("FAIL alu_beats_load: got %h expected %h", bus_out, 16'h00AC); end
    read_en = 4'd3; #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL bus_code3: got %h expected %h", bus_out, 16'h0000); end
    read_en = 4'd14; #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL bus_code14: got %h expected %h", bus_out, 16'h0000); end
  endtask

  initial begin
    reset_n    = 1'b0;
    read_en    = '0;
    write_en   = '0;
    inc_en     = '0;
    alu_op     = '0;
    imem_rdata = '0;
    dmem_rdata = '0;
    #12;
    reset_n = 1'b1;
    #10;
    test_reset();
    test_immediate_load();
    test_subtract();
    test_store();
    test_wrap_shift();
    test_regfile();
    test_conflicts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_regs.md
Name: datapath_regs

Overview:
- Datapath register bank and shared bus that answers the control unit's control word (read_en, write_en, inc_en, alu_op) each cycle.
- Returns instruction and z to the control unit.
- Holds PC, DAR, IR, AC, R, R1–R5 and a z flag, plus a small ALU.
- Drives address, data and write-enable for external instruction and data memories.

Parameters:
- WIDTH, 16, width of bus and of every register.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- read_en  input  4  bus source select.
- write_en  input  16  one-hot-per-bit load enables.
- inc_en  input  16  increment enables.
- alu_op  input  3  ALU function.
- imem_rdata  input  WIDTH  instruction memory read data.
- dmem_rdata  input  WIDTH  data memory read data.
- imem_addr  output  WIDTH  equals PC.
- dmem_addr  output  WIDTH  equals DAR.
- dmem_wdata  output  WIDTH  equals current bus value.
- dmem_we  output  1  data memory write strobe.
- instruction  output  WIDTH  equals IR.
- z  output  WIDTH  zero flag, value 0 or 1, zero-extended.
- bus_out  output  WIDTH  current bus value, for debug.

Behaviour:
- Reset (reset_n low, asynchronous): PC, DAR, IR, AC, R, R1–R5 = 0; z = 0. Registers are held at 0 while reset_n is low, including mid-operation. Every output reflects the zeroed registers immediately.
- Bus is combinational from read_en:
  - 2 = DAR
  - 5 = AC
  - 6 = R
  - 7..11 = R1..R5
  - 12 = dmem_rdata
  - 13 = imem_rdata
  - all other codes (0, 1, 3, 4, 14, 15) = 0
- write_en bit map. Each selected register loads the bus on the rising clock edge:
  - bit 1 = PC
  - bit 2 = DAR
  - bit 4 = IR
  - bit 5 = AC
  - bits 6..11 = R, R1..R5
  - bit 12 = dmem_we
  - bit 14 = z update from ALU result
  - bit 15 = AC loads ALU result
  - bits 0, 3, 13 are ignored
- Multiple write_en bits may be set in one cycle. All selected destinations load the same bus value.
- dmem_we = write_en[12], combinational. dmem_addr = DAR and dmem_wdata = bus in the same cycle.
- ALU is combinational, with operands AC and R:
  - alu_op 1: AC + R
  - alu_op 2: AC − R
  - alu_op 3: AC << 1
  - alu_op 4: AC >> 1 (logical)
  - other codes: pass AC
- ALU results are truncated to WIDTH; carry and borrow are discarded.
- z flag:
  - write_en[14]: z <= (ALU result == 0) ? 1 : 0.
  - write_en[5] without write_en[14]: z <= (bus == 0) ? 1 : 0.
  - Otherwise z holds.
- inc_en bit map, increment by 1 on the rising edge, wrapping (all ones -> 0):
  - bit 1 = PC
  - bit 2 = AC
  - bit 3 = DAR
  - bit 4 = R1
  - bit 5 = R2
  - bit 6 = R3
  - other bits are ignored
- An AC increment does not change z.
- Priority per register: write_en[15] (ALU) > write_en[5] (bus) > inc_en > hold. For all other registers, the write_en load beats inc_en.
- Latency: a load or increment is visible on outputs one cycle after the enable cycle. instruction, imem_addr and dmem_addr are registered values; only bus-derived outputs and dmem_we are combinational.
- No internal state machine beyond the registers. The block is fully deterministic from the control word each cycle.

Test Plan:
- Reset: assert reset_n = 0 mid-run with PC = 0x0012 and AC = 0x00FF -> all registers, z, imem_addr and instruction read 0 without a clock edge. Release reset, then apply an idle control word for 3 cycles -> values stay 0.
- Immediate load: read_en = 13, imem_rdata = 0x00A5, write_en bit 5 for 1 cycle -> AC = 0x00A5, z = 0. Then read_en = 5 with write_en bit 6 -> R = 0x00A5, bus_out = 0x00A5.
- Subtract: AC = R = 0x00A5, alu_op = 2, write_en = 0xC000 -> AC = 0x0000, z = 1. Next, alu_op = 1 with AC = 0 and R = 0x00A5, write_en = 0xC000 -> AC = 0x00A5, z = 0.
- Store: DAR = 0x0030, AC = 0x1234, read_en = 5, write_en bit 12 -> in the same cycle, dmem_we = 1, dmem_addr = 0x0030, dmem_wdata = 0x1234. The following cycle, dmem_we = 0.
- Wrap and shift:
  - PC = 0xFFFF, inc_en = 0x0002 -> PC = 0x0000.
  - AC = 0x8001, alu_op = 3, write_en = 0xC000 -> AC = 0x0002.
  - AC = 0x8001, alu_op = 4, write_en = 0xC000 -> AC = 0x4000.
- Conflicts:
  - Same cycle: write_en bit 5 with bus = 0x0007, and inc_en bit 2 -> AC = 0x0007, no increment.
  - write_en bits 5 and 15 together with alu_op = 1 -> AC = ALU result.
  - read_en = 3 -> bus_out = 0.
